seq_cla_adder: RTL and testbench

Parametrised, multi-cycle WIDTH-bit adder/subtractor that reuses one 4-bit carry-lookahead slice, one nibble per clock, LSB nibble first. Replaces wide ripple/lookahead arrays where area matters more than latency. Operands enter through a valid/ready input handshake. The result, with carry, overflow and zero flags, leaves through a valid/ready output handshake. It sits in the datapath beside the combinational 4-bit adders as their area-optimised wide counterpart.

---
 rtl/adder_pkg.sv | 18 +
 rtl/cla_slice4.sv | 28 ++
 rtl/seq_cla_adder.sv | 133 +++++++++++++
 tb/tb_seq_cla_adder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and constants for the sequential carry-lookahead adder.
// The adder walks its operands one NIB_BITS-wide nibble per clock.
package adder_pkg;

  localparam int NIB_BITS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Signed overflow of a two-operand add, from the operand and result sign bits.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/cla_slice4.sv
// Combinational 4-bit carry-lookahead slice: every carry is formed directly
// from generate/propagate terms and ci, with no ripple between bit positions.
module cla_slice4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s  = p ^ c[3:0];
  assign co = c[4];

endmodule

// File: rtl/seq_cla_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor: one shared 4-bit lookahead slice
// processes a nibble per clock, LSB first, with the carry held in a register.
module seq_cla_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int NIB = WIDTH / NIB_BITS;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  if ((WIDTH % NIB_BITS) != 0 || WIDTH < NIB_BITS) begin : g_bad_width
    $error("seq_cla_adder: WIDTH must be a non-zero multiple of 4");
  end

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             c_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [3:0]       slice_s;
  logic             c_d;
  logic [WIDTH-1:0] sum_d;
  logic             last_nib;

  // Shifting by the nibble offset avoids an index whose width depends on NIB.
  assign nib_a    = 4'(a_q >> {cnt_q, 2'b00});
  assign nib_b    = 4'(b_q >> {cnt_q, 2'b00});
  assign last_nib = (cnt_q == CW'(NIB - 1));

  cla_slice4 u_slice (
    .a  (nib_a),
    .b  (nib_b),
    .ci (c_q),
    .s  (slice_s),
    .co (c_d)
  );

  for (genvar gi = 0; gi < NIB; gi++) begin : g_merge
    assign sum_d[NIB_BITS*gi +: NIB_BITS] =
      (cnt_q == CW'(gi)) ? slice_s : sum_q[NIB_BITS*gi +: NIB_BITS];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          if (in_valid && in_ready_q) begin
            // Subtraction becomes A + ~B + ~borrow so the slice only ever adds.
            a_q        <= a;
            b_q        <= sub ? ~b : b;
            c_q        <= sub ? ~cin : cin;
            cnt_q      <= '0;
            sum_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          sum_q <= sum_d;
          c_q   <= c_d;
          cnt_q <= cnt_q + CW'(1);
          if (last_nib) begin
            cnt_q       <= '0;
            cout_q      <= c_d;
            ovf_q       <= signed_ovf(a_q[WIDTH-1], b_q[WIDTH-1], slice_s[3]);
            zero_q      <= (sum_d == '0);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_seq_cla_adder.sv
// Bench for seq_cla_adder: arithmetic reference model plus directed vectors,
// with extra 4-bit and 32-bit instances for the width boundary cases.
module tb_seq_cla_adder;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid, in_ready, cin, sub, out_valid, out_ready;
  logic [W-1:0] a, b, sum;
  logic         cout, overflow, zero;

  logic        v4, r4, ov4, co4, of4, z4;
  logic [3:0]  a4, b4, s4;
  logic        v32, r32, ov32, co32, of32, z32;
  logic [31:0] a32, b32, s32;
  logic        tie0 = 1'b0;
  logic        tie1 = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_acc = 0;

  seq_cla_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .overflow(overflow), .zero(zero)
  );

  seq_cla_adder #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(r4),
    .a(a4), .b(b4), .cin(tie0), .sub(tie0), .out_valid(ov4), .out_ready(tie1),
    .sum(s4), .cout(co4), .overflow(of4), .zero(z4)
  );

  seq_cla_adder #(.WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(r32),
    .a(a32), .b(b32), .cin(tie0), .sub(tie0), .out_valid(ov32), .out_ready(tie1),
    .sum(s32), .cout(co32), .overflow(of32), .zero(z32)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operands.
  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    logic         z;
    int           acc;
    logic         seen;
  } exp_t;

  exp_t q[$];

  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                 input logic tc, input logic ts, input int acc);
    exp_t   e;
    longint ua, ub, sa, sb, ci, ru, rs;
    ua = longint'(ta);
    ub = longint'(tb_);
    sa = longint'($signed(ta));
    sb = longint'($signed(tb_));
    ci = tc ? 64'sd1 : 64'sd0;
    ru = ts ? (ua - ub - ci) : (ua + ub + ci);
    rs = ts ? (sa - sb - ci) : (sa + sb + ci);
    e.s    = W'(ru);
    e.c    = ts ? (ua >= ub + ci) : (ru >= (longint'(1) << W));
    e.o    = (rs > (longint'(1) << (W - 1)) - 1) || (rs < -(longint'(1) << (W - 1)));
    e.z    = (e.s == '0);
    e.acc  = acc;
    e.seen = 1'b0;
    return e;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      q.delete();
    end else begin
      if (out_valid === 1'b1 && out_ready === 1'b1 && q.size() > 0) void'(q.pop_front());
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        q.push_back(model(a, b, cin, sub, cyc));
        last_acc = cyc;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (out_valid === 1'b1) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", 1, 0);
        end else begin
          if (!q[0].seen) begin
            chk("latency", 64'(cyc - q[0].acc), NIB);
            q[0].seen = 1'b1;
          end
          $display("result sum=%h cout=%b ovf=%b zero=%b (exp %h %b %b %b)",
                   sum, cout, overflow, zero, q[0].s, q[0].c, q[0].o, q[0].z);
          chk("model_sum", sum, q[0].s);
          chk("model_cout", cout, q[0].c);
          chk("model_ovf", overflow, q[0].o);
          chk("model_zero", zero, q[0].z);
        end
      end
      if (q.size() > 0) chk("busy_in_ready", in_ready, 0);
    end
  end

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc, input logic ts);
    int n;
    a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("accept_timeout", 1, 0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string name, input logic [W-1:0] es,
                             input logic ec, input logic eo, input logic ez);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_sum"}, sum, es);
    chk({name, "_cout"}, cout, ec);
    chk({name, "_ovf"}, overflow, eo);
    chk({name, "_zero"}, zero, ez);
    @(negedge clk);
  endtask

  typedef struct {
    logic [W-1:0] a, b;
    logic         c, s;
    logic [W-1:0] es;
    logic         ec, eo, ez;
  } vec_t;

  vec_t vecs[12] = '{
    '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0},
    '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1},
    '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0},
    '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0},
    '{16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0, 1'b0},
    '{16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0, 1'b0},
    '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1},
    '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1},
    '{16'hABCD, 16'h1234, 1'b0, 1'b0, 16'hBE01, 1'b0, 1'b0, 1'b0},
    '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0},
    '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0},
    '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0}
  };

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (compared %0d)", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] hs;
    logic         hc, ho, hz;
    int           n, t0, t1;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    v4 = 1'b0; a4 = '0; b4 = '0; v32 = 1'b0; a32 = '0; b32 = '0;

    @(negedge clk);
    chk("rst_sum", sum, 0);
    chk("rst_flags", {cout, overflow, zero}, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    foreach (vecs[i]) begin
      $display("vec %0d: a=%h b=%h cin=%b sub=%b", i, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].s);
      send(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].s);
      wait_result($sformatf("vec%0d", i), vecs[i].es, vecs[i].ec, vecs[i].eo, vecs[i].ez);
    end

    // Back-to-back with in_valid held; operands change while the first op runs.
    a = 16'h0001; b = 16'h0002; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    t0 = last_acc;
    a = 16'h4000; b = 16'h4000;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    t1 = last_acc;
    in_valid = 1'b0;
    $display("back-to-back accepts at %0d and %0d", t0, t1);
    chk("b2b_period", 64'(t1 - t0), NIB + 2);
    wait_result("b2b_second", 16'h8000, 1'b0, 1'b1, 1'b0);

    // Backpressure: result must hold and no new operands accepted.
    out_ready = 1'b0;
    send(16'h00FF, 16'h0001, 1'b0, 1'b0);
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    hs = sum; hc = cout; ho = overflow; hz = zero;
    chk("bp_sum", hs, 16'h0100);
    a = 16'hDEAD; b = 16'hBEEF; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      $display("backpressure cycle %0d: sum=%h out_valid=%b in_ready=%b", i, sum, out_valid, in_ready);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_in_ready", in_ready, 0);
      chk("bp_hold_result", {sum, cout, overflow, zero}, {hs, hc, ho, hz});
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_out_valid", out_valid, 0);

    // Reset asserted in the second RUN cycle aborts the operation.
    send(16'h1234, 16'h1111, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    $display("mid-run reset: sum=%h out_valid=%b in_ready=%b", sum, out_valid, in_ready);
    chk("midrst_outputs", {sum, cout, overflow, zero, out_valid, in_ready}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrst_no_valid", out_valid, 0);
    end
    send(16'h1234, 16'h1111, 1'b0, 1'b0);
    wait_result("after_rst", 16'h2345, 1'b0, 1'b0, 1'b0);

    // 4-bit instance: single-cycle latency.
    a4 = 4'hF; b4 = 4'h1; v4 = 1'b1;
    n = 0;
    while (r4 !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    v4 = 1'b0;
    n = 0;
    while (ov4 !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    $display("w4: sum=%h cout=%b zero=%b latency=%0d", s4, co4, z4, n);
    chk("w4_latency", 64'(n), 1);
    chk("w4_result", {s4, co4, of4, z4}, {4'h0, 1'b1, 1'b0, 1'b1});

    // 32-bit instance: eight-cycle latency.
    a32 = 32'hFFFF_FFFF; b32 = 32'h1; v32 = 1'b1;
    n = 0;
    while (r32 !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    v32 = 1'b0;
    n = 0;
    while (ov32 !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    $display("w32: sum=%h cout=%b zero=%b latency=%0d", s32, co32, z32, n);
    chk("w32_latency", 64'(n), 8);
    chk("w32_result", {s32, co32, of32, z32}, {32'h0, 1'b1, 1'b0, 1'b1});

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
